// File: rtl/rfile_host_if.sv
// Host-side job/result bus and solver pin bundle for rfile_host.
// The host interface carries job offers and results; the solver interface carries the RFILE pins.
interface rfile_host_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      in_pos;
  logic [59:0]      in_rssi;
  logic [47:0]      in_value;
  logic [TAG_W-1:0] in_tag;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_xt;
  logic [7:0]       res_yt;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    output in_valid, in_pos, in_rssi, in_value, in_tag, res_ready,
    input  in_ready, res_valid, res_xt, res_yt, res_tag, res_err
  );

  modport slave (
    input  in_valid, in_pos, in_rssi, in_value, in_tag, res_ready,
    output in_ready, res_valid, res_xt, res_yt, res_tag, res_err
  );
endinterface

interface rfile_sol_if;
  logic        sol_rst;
  logic [7:0]  A_x, A_y, B_x, B_y, C_x, C_y;
  logic [19:0] rssiA, rssiB, rssiC;
  logic [15:0] valueA, valueB, valueC;
  logic        busy;
  logic        out_valid;
  logic [7:0]  xt;
  logic [7:0]  yt;

  modport master (
    output sol_rst, A_x, A_y, B_x, B_y, C_x, C_y,
           rssiA, rssiB, rssiC, valueA, valueB, valueC,
    input  busy, out_valid, xt, yt
  );

  modport slave (
    input  sol_rst, A_x, A_y, B_x, B_y, C_x, C_y,
           rssiA, rssiB, rssiC, valueA, valueB, valueC,
    output busy, out_valid, xt, yt
  );
endinterface

// File: rtl/rfile_host.sv
// Job sequencer / result collector for the RFILE trilateration solver.
// Input job FIFO -> held solver pins -> result FIFO, with a per-solve watchdog.
module rfile_host #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 96
) (
  input  logic          clk,
  input  logic          rst,
  rfile_host_if.slave   host,
  rfile_sol_if.master   sol
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IW  = 48 + 60 + 48 + TAG_W;
  localparam int RW  = TAG_W + 8 + 8 + 1;
  localparam int WDW = $clog2(TIMEOUT) + 1;

  localparam logic [IAW:0] IP_ONE   = (IAW+1)'(1);
  localparam logic [OAW:0] OP_ONE   = (OAW+1)'(1);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic {IDLE, RUN} state_e;

  // ---------------- input job FIFO ----------------
  logic [IW-1:0] in_mem [IN_DEPTH];
  logic [IAW:0]  in_wr_q, in_rd_q;
  logic          in_empty, in_full, in_push, in_pop;
  logic [IW-1:0] in_head;

  assign in_empty = (in_wr_q == in_rd_q);
  assign in_full  = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                    (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_push  = host.in_valid && !in_full;
  assign in_head  = in_mem[in_rd_q[IAW-1:0]];
  assign host.in_ready = !in_full;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_q[IAW-1:0]] <= {host.in_pos, host.in_rssi, host.in_value, host.in_tag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q <= '0;
      in_rd_q <= '0;
    end else begin
      if (in_push) in_wr_q <= in_wr_q + IP_ONE;
      if (in_pop)  in_rd_q <= in_rd_q + IP_ONE;
    end
  end

  // ---------------- result FIFO ----------------
  logic [RW-1:0] res_mem [OUT_DEPTH];
  logic [OAW:0]  res_wr_q, res_rd_q;
  logic [OAW:0]  res_count;
  logic          res_empty, res_push, res_pop;
  logic [RW-1:0] res_wdata, res_head;

  assign res_count = res_wr_q - res_rd_q;
  assign res_empty = (res_count == '0);
  assign res_pop   = !res_empty && host.res_ready;
  assign res_head  = res_mem[res_rd_q[OAW-1:0]];
  assign host.res_valid = !res_empty;
  assign {host.res_tag, host.res_xt, host.res_yt, host.res_err} = res_empty ? '0 : res_head;

  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wr_q[OAW-1:0]] <= res_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_wr_q <= '0;
      res_rd_q <= '0;
    end else begin
      if (res_push) res_wr_q <= res_wr_q + OP_ONE;
      if (res_pop)  res_rd_q <= res_rd_q + OP_ONE;
    end
  end

  // ---------------- sequencer ----------------
  state_e           state_q;
  logic             sol_rst_q;
  logic [47:0]      pos_q;
  logic [59:0]      rssi_q;
  logic [47:0]      value_q;
  logic [TAG_W-1:0] cur_tag_q;
  logic [WDW-1:0]   wdog_q;

  logic       done, timeout, launch_idle, chain;
  logic [OAW:0] occ_d;

  assign done        = (state_q == RUN) && sol.out_valid;
  assign timeout     = (state_q == RUN) && !sol.out_valid && (wdog_q == WD_LAST);
  assign launch_idle = (state_q == IDLE) && !in_empty && (res_count < OUT_FULL);
  // Occupancy after this edge counts the result being pushed now, so a chained
  // launch always has a free result slot waiting for it.
  assign occ_d       = res_count + OP_ONE - (res_pop ? OP_ONE : '0);
  assign chain       = done && !in_empty && (occ_d < OUT_FULL);
  assign in_pop      = launch_idle || chain;

  assign res_push  = done || timeout;
  assign res_wdata = done ? {cur_tag_q, sol.xt, sol.yt, 1'b0}
                          : {cur_tag_q, 8'h00, 8'h00, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sol_rst_q <= 1'b1;
      pos_q     <= '0;
      rssi_q    <= '0;
      value_q   <= '0;
      cur_tag_q <= '0;
      wdog_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sol_rst_q <= 1'b1;
          if (launch_idle) begin
            {pos_q, rssi_q, value_q, cur_tag_q} <= in_head;
            sol_rst_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          wdog_q <= wdog_q + WD_ONE;
          if (done) begin
            if (chain) begin
              {pos_q, rssi_q, value_q, cur_tag_q} <= in_head;
              wdog_q <= '0;
            end else begin
              sol_rst_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (timeout) begin
            sol_rst_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          sol_rst_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign sol.sol_rst = sol_rst_q;
  assign {sol.A_x, sol.A_y, sol.B_x, sol.B_y, sol.C_x, sol.C_y} = pos_q;
  assign {sol.rssiA, sol.rssiB, sol.rssiC}    = rssi_q;
  assign {sol.valueA, sol.valueB, sol.valueC} = value_q;

endmodule

// File: tb/tb_rfile_host.sv
// Directed bench for rfile_host with a fixed-latency solver stand-in (xt/yt = coordinate sums).
module tb_rfile_host;
  localparam int TAG_W     = 4;
  localparam int SOLVE_LAT = 10;
  localparam int TIMEOUT   = 96;

  typedef struct {
    logic [47:0]      pos;
    logic [59:0]      rssi;
    logic [47:0]      value;
    logic [TAG_W-1:0] tag;
    logic [7:0]       xt;
    logic [7:0]       yt;
    logic             err;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [7:0]       xt;
    logic [7:0]       yt;
    logic             err;
    int               cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rfile_host_if #(.TAG_W(TAG_W)) host();
  rfile_sol_if sol();

  rfile_host #(.IN_DEPTH(4), .OUT_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .sol  (sol)
  );

  // Solver stand-in: leaves READY the cycle after sol_rst falls, done pulse after SOLVE_LAT cycles.
  logic hang = 1'b0;
  logic ov_force = 1'b0;
  int unsigned scnt = 0;
  always @(posedge clk) begin
    if (sol.sol_rst || scnt == SOLVE_LAT) scnt <= 0;
    else scnt <= scnt + 1;
  end
  assign sol.out_valid = ov_force || (!sol.sol_rst && !hang && scnt == SOLVE_LAT);
  assign sol.busy      = !sol.sol_rst && (scnt != SOLVE_LAT);
  assign sol.xt        = sol.A_x + sol.B_x + sol.C_x;
  assign sol.yt        = sol.A_y + sol.B_y + sol.C_y;

  logic [155:0] pins;
  assign pins = {sol.A_x, sol.A_y, sol.B_x, sol.B_y, sol.C_x, sol.C_y,
                 sol.rssiA, sol.rssiB, sol.rssiC, sol.valueA, sol.valueB, sol.valueC};

  // Monitor: collects popped results, counts sol_rst rises and pin changes not preceded by out_valid.
  res_t rq[$];
  res_t mon_r;
  int cyc = 0;
  int rises = 0;
  int chg_noov = 0;
  logic [155:0] pins_last = '0;
  logic ov_last = 1'b0;
  logic srst_last = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (host.res_valid && host.res_ready) begin
      mon_r.tag = host.res_tag;
      mon_r.xt  = host.res_xt;
      mon_r.yt  = host.res_yt;
      mon_r.err = host.res_err;
      mon_r.cyc = cyc;
      rq.push_back(mon_r);
    end
    if (sol.sol_rst && !srst_last) rises++;
    if (pins != pins_last && !ov_last) chg_noov++;
    pins_last = pins;
    ov_last   = sol.out_valid;
    srst_last = sol.sol_rst;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] ax, input logic [7:0] ay,
                              input logic [7:0] bx, input logic [7:0] by,
                              input logic [7:0] cx, input logic [7:0] cy,
                              input logic [TAG_W-1:0] tag,
                              input logic [7:0] xt, input logic [7:0] yt, input logic err);
    vec_t v;
    v.pos   = {ax, ay, bx, by, cx, cy};
    v.rssi  = {tag, 16'hA1A1, tag, 16'hB2B2, tag, 16'hC3C3};
    v.value = {tag, 12'h111, tag, 12'h222, tag, 12'h333};
    v.tag   = tag;
    v.xt    = xt;
    v.yt    = yt;
    v.err   = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    host.in_valid = 1'b1;
    host.in_pos   = v.pos;
    host.in_rssi  = v.rssi;
    host.in_value = v.value;
    host.in_tag   = v.tag;
  endtask

  task automatic push(input vec_t v, input string name);
    int k;
    drive(v);
    k = 0;
    while (!host.in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!host.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready stayed low, got 0 required 1", name);
    end
    @(negedge clk);
    host.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input string name);
    int k;
    k = 0;
    while (rq.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (rq.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d results required %0d", name, rq.size(), n);
    end
  endtask

  task automatic check_res(input vec_t v, input string name);
    res_t r;
    if (rq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no result required tag %0d", name, v.tag);
      return;
    end
    r = rq.pop_front();
    chk({name, "_tag"}, 160'(r.tag), 160'(v.tag));
    chk({name, "_xt"},  160'(r.xt),  160'(v.xt));
    chk({name, "_yt"},  160'(r.yt),  160'(v.yt));
    chk({name, "_err"}, 160'(r.err), 160'(v.err));
  endtask

  vec_t tbl[16];
  int base_r, base_c, t0, k;
  res_t r;

  initial begin
    tbl[0]  = mk(8'd0,   8'd0,   8'd100, 8'd0,   8'd0,   8'd100, 4'd3,  8'd100, 8'd100, 1'b0);
    tbl[1]  = mk(8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  4'd1,  8'd90,  8'd120, 1'b0);
    tbl[2]  = mk(8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   4'd2,  8'd9,   8'd12,  1'b0);
    tbl[3]  = mk(8'd200, 8'd100, 8'd50,  8'd100, 8'd10,  8'd60,  4'd3,  8'd4,   8'd4,   1'b0);
    tbl[4]  = mk(8'd255, 8'd0,   8'd255, 8'd0,   8'd255, 8'd1,   4'd4,  8'd253, 8'd1,   1'b0);
    tbl[5]  = mk(8'd7,   8'd7,   8'd7,   8'd7,   8'd7,   8'd7,   4'd5,  8'd21,  8'd21,  1'b0);
    tbl[6]  = mk(8'd16,  8'd32,  8'd48,  8'd64,  8'd80,  8'd96,  4'd6,  8'd144, 8'd192, 1'b0);
    tbl[7]  = mk(8'd100, 8'd1,   8'd100, 8'd1,   8'd100, 8'd1,   4'd7,  8'd44,  8'd3,   1'b0);
    tbl[8]  = mk(8'd0,   8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   4'd8,  8'd0,   8'd255, 1'b0);
    tbl[9]  = mk(8'd128, 8'd64,  8'd64,  8'd32,  8'd32,  8'd16,  4'd9,  8'd224, 8'd112, 1'b0);
    tbl[10] = mk(8'd9,   8'd8,   8'd7,   8'd6,   8'd5,   8'd4,   4'd10, 8'd21,  8'd18,  1'b0);
    tbl[11] = mk(8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   4'd11, 8'd0,   8'd0,   1'b1);
    tbl[12] = mk(8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  8'd70,  4'd12, 8'd120, 8'd150, 1'b0);
    tbl[13] = mk(8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   4'd13, 8'd9,   8'd9,   1'b0);
    tbl[14] = mk(8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   4'd14, 8'd12,  8'd12,  1'b0);
    tbl[15] = mk(8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   4'd15, 8'd15,  8'd15,  1'b0);

    host.in_valid  = 1'b0;
    host.in_pos    = '0;
    host.in_rssi   = '0;
    host.in_value  = '0;
    host.in_tag    = '0;
    host.res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  160'(host.in_ready),  160'(1));
    chk("rst_res_valid", 160'(host.res_valid), 160'(0));
    chk("rst_sol_rst",   160'(sol.sol_rst),    160'(1));
    chk("rst_pins",      160'(pins),           160'(0));
    chk("rst_res_bus",   160'({host.res_tag, host.res_xt, host.res_yt, host.res_err}), 160'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single job: launch one cycle after accept, pins stable, back to IDLE
    host.res_ready = 1'b1;
    drive(tbl[0]);
    chk("t1_in_ready", 160'(host.in_ready), 160'(1));
    @(negedge clk);
    host.in_valid = 1'b0;
    chk("t1_srst_at_accept", 160'(sol.sol_rst), 160'(1));
    @(negedge clk);
    chk("t1_srst_launched", 160'(sol.sol_rst), 160'(0));
    chk("t1_pins", 160'(pins), 160'({tbl[0].pos, tbl[0].rssi, tbl[0].value}));
    wait_res(1, "t1_wait");
    check_res(tbl[0], "t1");
    chk("t1_srst_idle", 160'(sol.sol_rst), 160'(1));

    // Four back-to-back jobs, results in order, sol_rst held low between solves
    base_r = rises;
    base_c = chg_noov;
    for (int i = 1; i <= 4; i++) push(tbl[i], "t2_push");
    wait_res(4, "t2_wait");
    for (int i = 1; i <= 4; i++) check_res(tbl[i], "t2");
    chk("t2_srst_rises", 160'(rises - base_r), 160'(1));
    chk("t2_pin_changes_without_done", 160'(chg_noov - base_c), 160'(1));

    // Result FIFO full: four results queue, fifth job waits for a pop
    host.res_ready = 1'b0;
    for (int i = 5; i <= 9; i++) push(tbl[i], "t3_push");
    chk("t3_in_full", 160'(host.in_ready), 160'(0));
    push(tbl[10], "t3_push6");
    repeat (120) @(negedge clk);
    chk("t3_res_valid",   160'(host.res_valid), 160'(1));
    chk("t3_head_tag",    160'(host.res_tag),   160'(tbl[5].tag));
    chk("t3_stalled_srst", 160'(sol.sol_rst),   160'(1));
    chk("t3_in_ready",    160'(host.in_ready),  160'(1));
    chk("t3_no_pops",     160'(rq.size()),      160'(0));
    host.res_ready = 1'b1;
    wait_res(6, "t3_wait");
    for (int i = 5; i <= 10; i++) check_res(tbl[i], "t3");

    // Watchdog: hung solver faults exactly TIMEOUT cycles after launch
    hang = 1'b1;
    push(tbl[11], "t4_push");
    k = 0;
    while (sol.sol_rst && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t4_launched", 160'(sol.sol_rst), 160'(0));
    t0 = cyc;
    wait_res(1, "t4_wait");
    if (rq.size() > 0) begin
      r = rq[0];
      chk("t4_latency", 160'(r.cyc - t0), 160'(TIMEOUT));
    end
    check_res(tbl[11], "t4");
    chk("t4_srst", 160'(sol.sol_rst), 160'(1));
    hang = 1'b0;
    push(tbl[12], "t4_next_push");
    wait_res(1, "t4_next_wait");
    check_res(tbl[12], "t4_next");

    // Reset mid-solve with two queued jobs
    for (int i = 13; i <= 15; i++) push(tbl[i], "t5_push");
    chk("t5_solving", 160'(sol.sol_rst), 160'(0));
    #2 rst = 1'b0;
    #1;
    chk("t5_srst",      160'(sol.sol_rst),    160'(1));
    chk("t5_res_valid", 160'(host.res_valid), 160'(0));
    chk("t5_in_ready",  160'(host.in_ready),  160'(1));
    chk("t5_pins",      160'(pins),           160'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_no_results", 160'(rq.size()),      160'(0));
    chk("t5_idle_srst",  160'(sol.sol_rst),    160'(1));

    // Spurious done pulse while idle
    ov_force = 1'b1;
    @(negedge clk);
    ov_force = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_res_valid", 160'(host.res_valid), 160'(0));
    chk("t6_no_results", 160'(rq.size()),     160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule
